core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Sequences a vanilla core's run state from network control commands: start at a PC, halt, resume, clear error.
- Owns the state register and the freeze signal that gates the core pipeline.
- Serialises the PC-write and halt-drain handshakes against the core stall.
- Sits between the remote-store decoder (command side) and the core front end (PC load, freeze).

Parameters:
- pc_width_p, 22, width of the PC value carried by a START command.
- timeout_p, 1024, stall-cycle limit for LOAD/DRAIN; used only with the watchdog feature.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cmd_v_i  in  1  command valid
- cmd_i  in  2  command code: START=0, HALT=1, RESUME=2, CLEAR=3
- cmd_pc_i  in  pc_width_p  start PC, sampled only for START
- cmd_ready_o  out  1  command can be accepted this cycle
- cmd_done_o  out  1  one-cycle pulse when the accepted command completes
- cmd_err_o  out  1  qualifies cmd_done_o; command was rejected or aborted
- stall_i  in  1  core pipeline stalled
- err_i  in  1  fatal core error (e.g. illegal instruction)
- pc_write_v_o  out  1  load pc_write_data_o into the core PC
- pc_write_data_o  out  pc_width_p  latched start PC
- freeze_o  out  1  core frozen
- state_o  out  3  current run state (run_state_e)

Behaviour:
- States: IDLE=0, LOAD=1, RUN=2, DRAIN=3, HALTED=4, ERR=5. All other encodings go to ERR next cycle.
- Reset: state IDLE, cmd_ready_o=0, cmd_done_o=0, cmd_err_o=0, pc_write_v_o=0, pc_write_data_o=0, freeze_o=1. Reset mid-LOAD or mid-DRAIN drops the pending command without a done pulse.
- cmd_ready_o=1 in IDLE, RUN, HALTED, ERR; 0 in LOAD, DRAIN, and during reset. A command is accepted when cmd_v_i & cmd_ready_o.
- freeze_o=1 in every state except RUN.
- Legal commands and transitions:
  - START in IDLE or HALTED: latch cmd_pc_i; next cycle enter LOAD.
  - HALT in RUN: enter DRAIN.
  - RESUME in HALTED: enter RUN; cmd_done_o pulses the cycle after accept.
  - CLEAR in ERR: enter IDLE; done pulses the cycle after accept; pc_write_data_o is unchanged.
- Illegal command for the current state: accepted; cmd_done_o=1 and cmd_err_o=1 the next cycle; state unchanged.
- LOAD: pc_write_v_o=1. The first cycle with stall_i=0 is the write cycle; in it cmd_done_o=1 and the next state is RUN. Latency is at least 1 cycle in LOAD.
- DRAIN: the first cycle with stall_i=0 pulses cmd_done_o and moves to HALTED.
- err_i has priority over everything:
  - In LOAD, RUN or DRAIN, the next state is ERR.
  - If a command is in flight (LOAD/DRAIN), it completes the same cycle with cmd_done_o=1, cmd_err_o=1.
  - err_i is ignored in IDLE, HALTED, ERR.
- If err_i and a new command arrive in the same RUN cycle, the command is still accepted. It is reported done with cmd_err_o=1 the next cycle and the state goes to ERR.
- cmd_done_o is at most one pulse per accepted command. cmd_err_o=0 whenever cmd_done_o=0.

Optional Feature:
- CORE_RUN_WATCHDOG_EN defined:
  - A log2(timeout_p+1)-bit counter clears on entry to LOAD/DRAIN and increments each cycle stall_i=1 in those states.
  - On reaching timeout_p: next state ERR, cmd_done_o=1, cmd_err_o=1.
  - The counter saturates and never wraps.
- CORE_RUN_WATCHDOG_EN undefined: no counter; LOAD/DRAIN wait indefinitely; timeout_p is unused.

Decomposition:
- Shared package (core_run_pkg): run_state_e, run_cmd_e, and a helper function returning whether a command is legal in a given state.
- One natural sub-module: core_run_watchdog (saturating counter plus compare), instantiated only under the macro.
- The FSM itself stays flat.

Test Plan:
- Reset, then START pc=0x1234 with stall_i=0: state IDLE→LOAD→RUN. pc_write_v_o=1 for exactly 1 cycle with data 0x1234. cmd_done_o=1, cmd_err_o=0 in that cycle. freeze_o drops in RUN.
- START while stall_i=1 for 5 cycles: pc_write_v_o held 6 cycles, cmd_ready_o=0 throughout, done on the 6th cycle.
- HALT in RUN with stall_i=1 for 3 cycles: DRAIN for 4 cycles, then HALTED. RESUME then reaches RUN with done 1 cycle after accept.
- RESUME issued in RUN: done+err next cycle, state stays RUN. CLEAR issued in IDLE: done+err, state stays IDLE.
- err_i during DRAIN: next state ERR with done+err. START in ERR: done+err. CLEAR: IDLE; a subsequent START pc=0x40 loads 0x40.
- With CORE_RUN_WATCHDOG_EN, timeout_p=8, stall_i stuck at 1 in LOAD: ERR after 8 stall cycles with done+err. Without the macro: remains in LOAD for 100 cycles.

Source files
------------

// File: rtl/core_run_pkg.sv
// Shared run-state and command encodings for the core run controller.
package core_run_pkg;

  typedef enum logic [2:0] {
    RS_IDLE   = 3'd0,
    RS_LOAD   = 3'd1,
    RS_RUN    = 3'd2,
    RS_DRAIN  = 3'd3,
    RS_HALTED = 3'd4,
    RS_ERR    = 3'd5
  } run_state_e;

  typedef enum logic [1:0] {
    CMD_START  = 2'd0,
    CMD_HALT   = 2'd1,
    CMD_RESUME = 2'd2,
    CMD_CLEAR  = 2'd3
  } run_cmd_e;

  // States in which a new command may be accepted.
  function automatic logic state_accepts(run_state_e s);
    return (s == RS_IDLE) || (s == RS_RUN) || (s == RS_HALTED) || (s == RS_ERR);
  endfunction

  function automatic logic cmd_legal(run_state_e s, run_cmd_e c);
    logic ok;
    ok = 1'b0;
    case (c)
      CMD_START:  ok = (s == RS_IDLE) || (s == RS_HALTED);
      CMD_HALT:   ok = (s == RS_RUN);
      CMD_RESUME: ok = (s == RS_HALTED);
      CMD_CLEAR:  ok = (s == RS_ERR);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/core_run_watchdog.sv
// Saturating stall counter for LOAD/DRAIN; expired_o flags the stall cycle that reaches timeout_p.
module core_run_watchdog #(
  parameter int unsigned timeout_p = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic active_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(timeout_p + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(timeout_p);
  localparam logic [CntW-1:0] CntLast = CntW'(timeout_p - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Held at zero outside LOAD/DRAIN, so every entry starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (stall_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && stall_i && (cnt_q >= CntLast);

endmodule

// File: rtl/core_run_ctrl.sv
// Run-state sequencer for a vanilla core: START/HALT/RESUME/CLEAR, PC load and freeze.
// Optional stall watchdog in LOAD/DRAIN enabled by defining CORE_RUN_WATCHDOG_EN.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned pc_width_p = 22,
  parameter int unsigned timeout_p  = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_v_i,
  input  logic [1:0]            cmd_i,
  input  logic [pc_width_p-1:0] cmd_pc_i,
  output logic                  cmd_ready_o,
  output logic                  cmd_done_o,
  output logic                  cmd_err_o,
  input  logic                  stall_i,
  input  logic                  err_i,
  output logic                  pc_write_v_o,
  output logic [pc_width_p-1:0] pc_write_data_o,
  output logic                  freeze_o,
  output logic [2:0]            state_o
);

  run_state_e            state_q, state_d;
  logic [pc_width_p-1:0] pc_q, pc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  freeze_q, freeze_d;
  logic                  pcv_q, pcv_d;
  logic                  in_flight, wd_expired, accept;
  logic                  flight_done, flight_err;
  run_cmd_e              cmd;

  assign cmd       = run_cmd_e'(cmd_i);
  assign in_flight = (state_q == RS_LOAD) || (state_q == RS_DRAIN);

`ifdef CORE_RUN_WATCHDOG_EN
  core_run_watchdog #(.timeout_p(timeout_p)) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .active_i  (in_flight),
    .stall_i   (stall_i),
    .expired_o (wd_expired)
  );
`else
  logic wd_unused;
  assign wd_unused  = (timeout_p == 0);
  assign wd_expired = 1'b0;
`endif

  assign cmd_ready_o = !reset_i && state_accepts(state_q);
  assign accept      = cmd_v_i && cmd_ready_o;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    flight_done = 1'b0;
    flight_err  = 1'b0;
    case (state_q)
      RS_IDLE, RS_RUN, RS_HALTED, RS_ERR: begin
        if (accept) begin
          if (!cmd_legal(state_q, cmd)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            case (cmd)
              CMD_START: begin
                pc_d    = cmd_pc_i;
                state_d = RS_LOAD;
              end
              CMD_HALT:   state_d = RS_DRAIN;
              CMD_RESUME: begin
                state_d = RS_RUN;
                done_d  = 1'b1;
              end
              default: begin
                state_d = RS_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        // A core error in RUN overrides any command taken in the same cycle.
        if ((state_q == RS_RUN) && err_i) begin
          state_d = RS_ERR;
          if (accept) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      RS_LOAD, RS_DRAIN: begin
        if (err_i || wd_expired) begin
          flight_done = 1'b1;
          flight_err  = 1'b1;
          state_d     = RS_ERR;
        end else if (!stall_i) begin
          flight_done = 1'b1;
          state_d     = (state_q == RS_LOAD) ? RS_RUN : RS_HALTED;
        end
      end
      default: state_d = RS_ERR;
    endcase
    freeze_d = (state_d != RS_RUN);
    pcv_d    = (state_d == RS_LOAD);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= RS_IDLE;
      pc_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      freeze_q <= 1'b1;
      pcv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      done_q   <= done_d;
      err_q    <= err_d;
      freeze_q <= freeze_d;
      pcv_q    <= pcv_d;
    end
  end

  // LOAD/DRAIN complete in the handshake cycle itself; the rest report one cycle after accept.
  assign cmd_done_o      = !reset_i && (done_q || flight_done);
  assign cmd_err_o       = !reset_i && (err_q || flight_err);
  assign pc_write_v_o    = pcv_q;
  assign pc_write_data_o = pc_q;
  assign freeze_o        = freeze_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl; watchdog scenario follows CORE_RUN_WATCHDOG_EN.
module tb_core_run_ctrl;

  localparam int PCW = 22;
  localparam logic [1:0] START = 2'd0, HALT = 2'd1, RESUME = 2'd2, CLEAR = 2'd3;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DRAIN = 3, S_HALTED = 4, S_ERR = 5;

  logic           clk = 1'b0;
  logic           reset_i, cmd_v_i, stall_i, err_i;
  logic [1:0]     cmd_i;
  logic [PCW-1:0] cmd_pc_i;
  logic           cmd_ready_o, cmd_done_o, cmd_err_o, pc_write_v_o, freeze_o;
  logic [PCW-1:0] pc_write_data_o;
  logic [2:0]     state_o;

  int n_tests = 0;
  int n_fail  = 0;

  core_run_ctrl #(.pc_width_p(PCW), .timeout_p(8)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .cmd_v_i         (cmd_v_i),
    .cmd_i           (cmd_i),
    .cmd_pc_i        (cmd_pc_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_done_o      (cmd_done_o),
    .cmd_err_o       (cmd_err_o),
    .stall_i         (stall_i),
    .err_i           (err_i),
    .pc_write_v_o    (pc_write_v_o),
    .pc_write_data_o (pc_write_data_o),
    .freeze_o        (freeze_o),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [PCW-1:0] pc);
    cmd_v_i  = 1'b1;
    cmd_i    = c;
    cmd_pc_i = pc;
  endtask

  task automatic done_chk(input string tag, input int st, input logic d, input logic e);
    @(negedge clk);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_done"}, 32'(cmd_done_o), 32'(d));
    chk({tag, "_err"}, 32'(cmd_err_o), 32'(e));
  endtask

  initial begin
    int load_cycles;
    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_i = 2'd0; cmd_pc_i = '0; stall_i = 1'b0; err_i = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_state", 32'(state_o), S_IDLE);
    chk("rst_ready", 32'(cmd_ready_o), 0);
    chk("rst_done", 32'(cmd_done_o), 0);
    chk("rst_err", 32'(cmd_err_o), 0);
    chk("rst_pcv", 32'(pc_write_v_o), 0);
    chk("rst_pcd", 32'(pc_write_data_o), 0);
    chk("rst_freeze", 32'(freeze_o), 1);
    step();
    reset_i = 1'b0;

    // START 0x1234, no stall
    issue(START, 22'h1234);
    @(negedge clk);
    chk("s1_ready_idle", 32'(cmd_ready_o), 1);
    step(); cmd_v_i = 1'b0;
    done_chk("s1_load", S_LOAD, 1'b1, 1'b0);
    chk("s1_pcv", 32'(pc_write_v_o), 1);
    chk("s1_pcd", 32'(pc_write_data_o), 32'h1234);
    chk("s1_ready_load", 32'(cmd_ready_o), 0);
    chk("s1_freeze_load", 32'(freeze_o), 1);
    step();
    done_chk("s1_run", S_RUN, 1'b0, 1'b0);
    chk("s1_pcv_off", 32'(pc_write_v_o), 0);
    chk("s1_freeze_run", 32'(freeze_o), 0);

    // HALT with 3 stall cycles, then RESUME
    issue(HALT, '0); stall_i = 1'b1;
    step(); cmd_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_chk("s3_drain_wait", S_DRAIN, 1'b0, 1'b0);
      chk("s3_ready_drain", 32'(cmd_ready_o), 0);
      step();
    end
    stall_i = 1'b0;
    done_chk("s3_drain_done", S_DRAIN, 1'b1, 1'b0);
    step();
    done_chk("s3_halted", S_HALTED, 1'b0, 1'b0);
    chk("s3_freeze_halted", 32'(freeze_o), 1);
    issue(RESUME, '0);
    step(); cmd_v_i = 1'b0;
    done_chk("s3_resume", S_RUN, 1'b1, 1'b0);
    step();
    done_chk("s3_resume_after", S_RUN, 1'b0, 1'b0);

    // Illegal RESUME in RUN
    issue(RESUME, '0);
    step(); cmd_v_i = 1'b0;
    done_chk("s4_bad_resume", S_RUN, 1'b1, 1'b1);
    step();

    // HALT without stall, then START 0xabc with 5 stall cycles from HALTED
    issue(HALT, '0);
    step(); cmd_v_i = 1'b0;
    done_chk("s2_drain1", S_DRAIN, 1'b1, 1'b0);
    step();
    issue(START, 22'h0abc); stall_i = 1'b1;
    step(); cmd_v_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      done_chk("s2_load_wait", S_LOAD, 1'b0, 1'b0);
      chk("s2_pcv_wait", 32'(pc_write_v_o), 1);
      chk("s2_ready_wait", 32'(cmd_ready_o), 0);
      step();
    end
    stall_i = 1'b0;
    done_chk("s2_load_done", S_LOAD, 1'b1, 1'b0);
    chk("s2_pcv_last", 32'(pc_write_v_o), 1);
    chk("s2_pcd", 32'(pc_write_data_o), 32'h0abc);
    step();
    done_chk("s2_run", S_RUN, 1'b0, 1'b0);

    // err_i during DRAIN
    issue(HALT, '0); stall_i = 1'b1;
    step(); cmd_v_i = 1'b0;
    done_chk("s5_drain", S_DRAIN, 1'b0, 1'b0);
    step(); err_i = 1'b1;
    done_chk("s5_drain_err", S_DRAIN, 1'b1, 1'b1);
    step(); err_i = 1'b0; stall_i = 1'b0;
    done_chk("s5_err", S_ERR, 1'b0, 1'b0);
    chk("s5_ready_err", 32'(cmd_ready_o), 1);
    chk("s5_freeze_err", 32'(freeze_o), 1);
    issue(START, 22'h999);
    step(); cmd_v_i = 1'b0;
    done_chk("s5_start_in_err", S_ERR, 1'b1, 1'b1);
    chk("s5_pcd_kept", 32'(pc_write_data_o), 32'h0abc);
    step();
    issue(CLEAR, '0);
    step(); cmd_v_i = 1'b0;
    done_chk("s5_clear", S_IDLE, 1'b1, 1'b0);
    chk("s5_pcd_after_clear", 32'(pc_write_data_o), 32'h0abc);
    step();
    issue(CLEAR, '0);
    step(); cmd_v_i = 1'b0;
    done_chk("s4_clear_in_idle", S_IDLE, 1'b1, 1'b1);
    step();
    issue(START, 22'h40);
    step(); cmd_v_i = 1'b0;
    done_chk("s5_load40", S_LOAD, 1'b1, 1'b0);
    chk("s5_pcd40", 32'(pc_write_data_o), 32'h40);
    step();

    // err_i and HALT in the same RUN cycle
    issue(HALT, '0); err_i = 1'b1;
    step(); cmd_v_i = 1'b0; err_i = 1'b0;
    done_chk("s6_err_and_cmd", S_ERR, 1'b1, 1'b1);
    step();
    done_chk("s6_single_pulse", S_ERR, 1'b0, 1'b0);
    issue(CLEAR, '0);
    step(); cmd_v_i = 1'b0;
    step();

    // Reset in the middle of LOAD drops the command silently
    issue(START, 22'h55); stall_i = 1'b1;
    step(); cmd_v_i = 1'b0;
    done_chk("s7_load", S_LOAD, 1'b0, 1'b0);
    reset_i = 1'b1; stall_i = 1'b0;
    @(negedge clk);
    chk("s7_rst_no_done", 32'(cmd_done_o), 0);
    step();
    @(negedge clk);
    chk("s7_rst_idle", 32'(state_o), S_IDLE);
    chk("s7_rst_pcv", 32'(pc_write_v_o), 0);
    step(); reset_i = 1'b0;

    // Stall stuck high in LOAD
    issue(START, 22'h7); stall_i = 1'b1;
    step(); cmd_v_i = 1'b0;
`ifdef CORE_RUN_WATCHDOG_EN
    for (int i = 0; i < 7; i++) begin
      done_chk("s8_wd_wait", S_LOAD, 1'b0, 1'b0);
      step();
    end
    done_chk("s8_wd_expire", S_LOAD, 1'b1, 1'b1);
    step();
    done_chk("s8_wd_err", S_ERR, 1'b0, 1'b0);
`else
    load_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state_o == 3'(S_LOAD) && !cmd_done_o) load_cycles++;
      step();
    end
    chk("s8_no_wd_load_cycles", 32'(load_cycles), 100);
`endif
    stall_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
